// File: rtl/shift_pkg.sv
//------------------------------------------------------------------------------
// Module : shift_pkg
// Brief  : Shared types and helpers for the shift_load_ctrl feeder.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package shift_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        ROTATE = 2'd2,
        CHECK  = 2'd3
    } state_t;

    function automatic int cnt_width(input int msb);
        return $clog2(msb + 1);
    endfunction

    // Rotations operate on the low w bits of a 64-bit carrier so one function serves any width.
    function automatic logic [63:0] rotl(input logic [63:0] v, input int w, input int n);
        logic [63:0] mask;
        logic [63:0] vm;
        mask = (64'd1 << w) - 64'd1;
        vm   = v & mask;
        return ((vm << n) | (vm >> (w - n))) & mask;
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] v, input int w, input int n);
        logic [63:0] mask;
        logic [63:0] vm;
        mask = (64'd1 << w) - 64'd1;
        vm   = v & mask;
        return ((vm >> n) | (vm << (w - n))) & mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/shift_frame_check.sv
//------------------------------------------------------------------------------
// Module : shift_frame_check
// Brief  : Holds the expected word and compares/captures the register on strobe.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module shift_frame_check
    import shift_pkg::*;
#(
    parameter int MSB = 8
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           load,
    input  logic [MSB-1:0] exp_in,
    input  logic           strobe,
    input  logic [MSB-1:0] sr_out,
    output logic           frame_done,
    output logic           frame_match,
    output logic [MSB-1:0] frame_word
);

    logic [MSB-1:0] r_exp;
    logic           r_done;
    logic           r_match;
    logic [MSB-1:0] r_word;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_exp   <= '0;
            r_done  <= 1'b0;
            r_match <= 1'b0;
            r_word  <= '0;
        end else begin
            r_done <= strobe;
            if (load) begin
                r_exp <= exp_in;
            end
            if (strobe) begin
                r_word  <= sr_out;
                r_match <= (sr_out == r_exp);
            end
        end
    end

    assign frame_done  = r_done;
    assign frame_match = r_match;
    assign frame_word  = r_word;

endmodule

`default_nettype wire

// File: rtl/shift_load_ctrl.sv
//------------------------------------------------------------------------------
// Module : shift_load_ctrl
// Brief  : Serializes a parallel word into bidir_shift_reg, rotates, then checks.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module shift_load_ctrl
    import shift_pkg::*;
#(
    parameter int MSB   = 8,
    parameter int CNT_W = cnt_width(MSB)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [MSB-1:0]   word_in,
    input  logic             dir_in,
    input  logic [CNT_W-1:0] rot_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             sr_d,
    output logic             sr_en,
    output logic             sr_dir,
    output logic             sr_circular,
    output logic             sr_carry_in,
    input  logic [MSB-1:0]   sr_out,
    output logic             busy,
    output logic             frame_done,
    output logic             frame_match,
    output logic [MSB-1:0]   frame_word
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(MSB - 1);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    state_t           r_state, w_state_nxt;
    logic [MSB-1:0]   r_word;
    logic             r_dir;
    logic [CNT_W-1:0] r_rot, r_bit_cnt, r_rot_cnt;
    logic [CNT_W-1:0] w_bit_cnt_nxt, w_rot_cnt_nxt;
    logic             r_chk_ph, w_chk_ph_nxt;
    logic             r_sr_d, r_sr_en, r_sr_circ, r_busy;
    logic             w_sr_d_nxt, w_sr_en_nxt, w_sr_circ_nxt;
    logic             w_accept, w_strobe;
    logic [CNT_W-1:0] w_rot_sat, w_next_idx, w_sel;
    logic [MSB-1:0]   w_word_sh, w_exp;

    assign w_rot_sat  = (rot_in >= CNT_W'(MSB)) ? c_LAST : rot_in;
    // Next bit position, mirrored for MSB-first loads; shifting avoids an over-wide index.
    assign w_next_idx = r_bit_cnt + c_ONE;
    assign w_sel      = r_dir ? w_next_idx : (c_LAST - w_next_idx);
    assign w_word_sh  = r_word >> w_sel;
    assign w_exp      = dir_in ? MSB'(rotr(64'(word_in), MSB, int'(w_rot_sat)))
                               : MSB'(rotl(64'(word_in), MSB, int'(w_rot_sat)));

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_rot_cnt_nxt = r_rot_cnt;
        w_chk_ph_nxt  = r_chk_ph;
        w_sr_d_nxt    = 1'b0;
        w_sr_en_nxt   = 1'b0;
        w_sr_circ_nxt = 1'b0;
        w_accept      = 1'b0;
        w_strobe      = 1'b0;
        case (r_state)
            IDLE: begin
                if (word_valid) begin
                    w_accept      = 1'b1;
                    w_state_nxt   = SHIFT;
                    w_bit_cnt_nxt = '0;
                    w_sr_en_nxt   = 1'b1;
                    w_sr_d_nxt    = dir_in ? word_in[0] : word_in[MSB-1];
                end
            end
            SHIFT: begin
                if (r_bit_cnt == c_LAST) begin
                    w_bit_cnt_nxt = '0;
                    if (r_rot != '0) begin
                        w_state_nxt   = ROTATE;
                        w_rot_cnt_nxt = '0;
                        w_sr_en_nxt   = 1'b1;
                        w_sr_circ_nxt = 1'b1;
                    end else begin
                        w_state_nxt  = CHECK;
                        w_chk_ph_nxt = 1'b0;
                    end
                end else begin
                    w_bit_cnt_nxt = w_next_idx;
                    w_sr_en_nxt   = 1'b1;
                    w_sr_d_nxt    = w_word_sh[0];
                end
            end
            ROTATE: begin
                if (r_rot_cnt == (r_rot - c_ONE)) begin
                    w_state_nxt  = CHECK;
                    w_chk_ph_nxt = 1'b0;
                end else begin
                    w_rot_cnt_nxt = r_rot_cnt + c_ONE;
                    w_sr_en_nxt   = 1'b1;
                    w_sr_circ_nxt = 1'b1;
                end
            end
            CHECK: begin
                // Strobe in the settle cycle so the registered done/match appear in the second.
                if (!r_chk_ph) begin
                    w_strobe     = 1'b1;
                    w_chk_ph_nxt = 1'b1;
                end else begin
                    w_chk_ph_nxt = 1'b0;
                    w_state_nxt  = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_word    <= '0;
            r_dir     <= 1'b0;
            r_rot     <= '0;
            r_bit_cnt <= '0;
            r_rot_cnt <= '0;
            r_chk_ph  <= 1'b0;
            r_sr_d    <= 1'b0;
            r_sr_en   <= 1'b0;
            r_sr_circ <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_rot_cnt <= w_rot_cnt_nxt;
            r_chk_ph  <= w_chk_ph_nxt;
            r_sr_d    <= w_sr_d_nxt;
            r_sr_en   <= w_sr_en_nxt;
            r_sr_circ <= w_sr_circ_nxt;
            r_busy    <= (w_state_nxt != IDLE);
            if (w_accept) begin
                r_word <= word_in;
                r_dir  <= dir_in;
                r_rot  <= w_rot_sat;
            end
        end
    end

    shift_frame_check #(
        .MSB (MSB)
    ) u_check (
        .clk         (clk),
        .rstn        (rstn),
        .load        (w_accept),
        .exp_in      (w_exp),
        .strobe      (w_strobe),
        .sr_out      (sr_out),
        .frame_done  (frame_done),
        .frame_match (frame_match),
        .frame_word  (frame_word)
    );

    assign word_ready  = (r_state == IDLE);
    assign busy        = r_busy;
    assign sr_d        = r_sr_d;
    assign sr_en       = r_sr_en;
    assign sr_dir      = r_dir;
    assign sr_circular = r_sr_circ;
    assign sr_carry_in = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_shift_load_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_shift_load_ctrl
// Brief  : Directed self-checking bench with a behavioural bidir_shift_reg.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_shift_load_ctrl;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] word_in = '0;
    logic       dir_in = 1'b0;
    logic [3:0] rot_in = '0;
    logic       word_valid = 1'b0;
    logic       word_ready, sr_d, sr_en, sr_dir, sr_circular, sr_carry_in;
    logic       busy, frame_done, frame_match;
    logic [7:0] frame_word, sr_out;
    logic [7:0] q;
    logic [7:0] flip = '0;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    shift_load_ctrl dut (
        .clk         (clk),
        .rstn        (rstn),
        .word_in     (word_in),
        .dir_in      (dir_in),
        .rot_in      (rot_in),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .sr_d        (sr_d),
        .sr_en       (sr_en),
        .sr_dir      (sr_dir),
        .sr_circular (sr_circular),
        .sr_carry_in (sr_carry_in),
        .sr_out      (sr_out),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_match (frame_match),
        .frame_word  (frame_word)
    );

    // Behavioural shift register: dir 0 moves toward MSB inserting at bit 0, dir 1 toward LSB.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= '0;
        end else if (sr_en) begin
            if (!sr_dir) q <= {q[6:0], sr_circular ? q[7] : sr_d};
            else         q <= {sr_circular ? q[0] : sr_d, q[7:1]};
        end
    end
    assign sr_out = q ^ flip;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_frame(input string name, input logic [7:0] w, input logic d,
                             input logic [3:0] r, input logic [7:0] exp_seq,
                             input int exp_rot, input logic [7:0] exp_word,
                             input logic exp_match, input logic [7:0] fmask);
        logic [7:0] seq;
        int n_shift, n_rot, n_done, done_k, ready_after;
        logic [7:0] fw;
        logic fm, dir_seen;
        seq = '0; n_shift = 0; n_rot = 0; n_done = 0; done_k = -1; ready_after = -1;
        fw = '0; fm = 1'b0; dir_seen = 1'b0;
        @(negedge clk);
        word_in = w; dir_in = d; rot_in = r; word_valid = 1'b1; flip = fmask;
        check({name, "_ready"}, 32'(word_ready), 32'd1);
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                word_valid = 1'b0;
                word_in = ~w;
                dir_in = ~d;
                dir_seen = sr_dir;
            end
            if (sr_en && !sr_circular) begin
                seq = {seq[6:0], sr_d};
                n_shift++;
            end
            if (sr_en && sr_circular) n_rot++;
            if (frame_done) begin
                n_done++;
                done_k = k;
                fw = frame_word;
                fm = frame_match;
            end
            if (done_k > 0 && k == done_k + 1) begin
                ready_after = int'(word_ready);
                break;
            end
        end
        flip = '0;
        check({name, "_seq"}, 32'(seq), 32'(exp_seq));
        check({name, "_nshift"}, 32'(n_shift), 32'd8);
        check({name, "_nrot"}, 32'(n_rot), 32'(exp_rot));
        check({name, "_dir"}, 32'(dir_seen), 32'(d));
        check({name, "_done_k"}, 32'(done_k), 32'(10 + exp_rot));
        check({name, "_ndone"}, 32'(n_done), 32'd1);
        check({name, "_word"}, 32'(fw), 32'(exp_word));
        check({name, "_match"}, 32'(fm), 32'(exp_match));
        check({name, "_ready_after"}, 32'(ready_after), 32'd1);
    endtask

    initial begin
        int acc;
        int n_done;
        #23;
        check("rst_ready", 32'(word_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_en", 32'(sr_en), 32'd0);
        check("rst_outs", 32'({sr_d, sr_dir, sr_circular, sr_carry_in, frame_done, frame_match}), 32'd0);
        check("rst_fword", 32'(frame_word), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        run_frame("basic", 8'hA5, 1'b0, 4'd0, 8'hA5, 0, 8'hA5, 1'b1, 8'h00);
        run_frame("lsb", 8'h0F, 1'b1, 4'd0, 8'hF0, 0, 8'h0F, 1'b1, 8'h00);
        run_frame("rot1", 8'hA5, 1'b0, 4'd1, 8'hA5, 1, 8'h4B, 1'b1, 8'h00);
        run_frame("rot4", 8'h0F, 1'b1, 4'd4, 8'hF0, 4, 8'hF0, 1'b1, 8'h00);
        run_frame("sat9", 8'h0F, 1'b1, 4'd9, 8'hF0, 7, 8'h1E, 1'b1, 8'h00);
        run_frame("mism", 8'h3C, 1'b0, 4'd0, 8'h3C, 0, 8'h3D, 1'b0, 8'h01);
        repeat (3) @(negedge clk);
        check("hold_match", 32'(frame_match), 32'd0);
        check("hold_word", 32'(frame_word), 32'h3D);
        check("carry_in", 32'(sr_carry_in), 32'd0);

        // Valid held continuously for 22 cycles: accepts at cycles 0 and 11 only.
        word_in = 8'h81; dir_in = 1'b0; rot_in = 4'd0; word_valid = 1'b1;
        acc = 0;
        for (int k = 0; k < 22; k++) begin
            if (word_ready && word_valid) acc++;
            @(negedge clk);
        end
        word_valid = 1'b0;
        check("held_accepts", 32'(acc), 32'd2);
        for (int k = 0; k < 30 && !word_ready; k++) @(negedge clk);
        check("held_idle", 32'(word_ready), 32'd1);
        @(negedge clk);

        // Reset during SHIFT bit 3.
        word_in = 8'hA5; dir_in = 1'b1; rot_in = 4'd0; word_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        word_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_en", 32'(sr_en), 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("abort_en", 32'(sr_en), 32'd0);
        check("abort_ready", 32'(word_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_outs", 32'({sr_d, sr_dir, sr_circular, frame_done, frame_match}), 32'd0);
        check("abort_fword", 32'(frame_word), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        n_done = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (frame_done) n_done++;
        end
        check("abort_nodone", 32'(n_done), 32'd0);
        check("abort_idle", 32'(word_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/shift_load_ctrl.md
Name: shift_load_ctrl

Overview:
Upstream feeder for bidir_shift_reg. Accepts a parallel word over a valid/ready handshake and serializes it into the shift register one bit per cycle by driving d/en/dir/circular/carry_in. After loading, it optionally rotates the word a programmed number of positions. It then samples the register's parallel out, compares it against the expected word, and reports completion and match.

Parameters:
MSB, 8, width of the shift register and data word (matches bidir_shift_reg MSB)
CNT_W, $clog2(MSB+1), width of the internal bit/rotation counters

Ports:
clk  input  1  system clock, all state updates on rising edge
rstn  input  1  asynchronous active-low reset
word_in  input  MSB  parallel word to load
dir_in  input  1  0: MSB-first load (register shifts toward MSB, inserts at bit 0); 1: LSB-first load (inserts at bit MSB-1)
rot_in  input  CNT_W  extra circular shifts after load, 0..MSB-1 (values >= MSB saturate to MSB-1)
word_valid  input  1  request, qualified with word_ready
word_ready  output  1  high only in IDLE
sr_d  output  1  serial bit to shift register d
sr_en  output  1  shift enable
sr_dir  output  1  direction to shift register, equals latched dir_in
sr_circular  output  1  high during ROTATE only
sr_carry_in  output  1  constant 0
sr_out  input  MSB  parallel out of shift register
busy  output  1  high in any state except IDLE
frame_done  output  1  one-cycle pulse at end of CHECK
frame_match  output  1  sr_out == expected, valid with frame_done, held until next frame_done
frame_word  output  MSB  sr_out captured in CHECK, held until next capture

Behaviour:
- Reset (async, rstn=0): state IDLE; word_ready=1; busy, sr_d, sr_en, sr_dir, sr_circular, sr_carry_in, frame_done, frame_match=0; frame_word=0; counters cleared. Reset mid-frame aborts the frame without a done pulse.
- All outputs are registered, except word_ready (decoded from state).
- IDLE: on word_valid && word_ready at edge T, latch word, dir, rot (saturated). Go to SHIFT. No new accept until back in IDLE.
- SHIFT: MSB cycles, T+1..T+MSB. sr_en=1, sr_circular=0.
  - dir=0: sr_d = word[MSB-1-i].
  - dir=1: sr_d = word[i].
  - i is a bit counter, 0..MSB-1.
  - After the last bit: go to ROTATE if rot!=0, else CHECK.
- ROTATE: rot cycles. sr_en=1, sr_circular=1, sr_d=0.
  - dir=0 rotates toward MSB: expected = rotl(word, rot).
  - dir=1 rotates toward LSB: expected = rotr(word, rot).
  - When rot=0, expected = word.
- CHECK: two cycles, sr_en=0.
  - Cycle 1: settle (sr_out reflects the last shift edge).
  - Cycle 2: capture frame_word<=sr_out, frame_match<=(sr_out==expected), pulse frame_done. Return to IDLE.
- Latency: accept at T; first sr_en at T+1; frame_done high in cycle T+MSB+rot+2; word_ready high again the following cycle.
- word_valid deasserting mid-frame has no effect. word_in changes after acceptance are ignored.
- sr_dir holds the latched dir from SHIFT start through CHECK, and keeps its value in IDLE.
- Back-to-back frames: a new accept is possible in the first IDLE cycle after frame_done, giving a minimum period of MSB+rot+3 cycles.

Decomposition:
- Package shift_pkg holds:
  - state enum {IDLE, SHIFT, ROTATE, CHECK} (2 bits)
  - localparam function for CNT_W
  - rotl/rotr functions parameterized on MSB
- One natural sub-module, shift_frame_check: latches the expected word, and on strobe does the compare/capture and generates frame_done, frame_match, frame_word.
- The FSM, counters and serializer stay in the top.

Test Plan:
- Basic load, MSB=8, word 8'hA5, dir=0, rot=0:
  - sr_d over T+1..T+8 = 1,0,1,0,0,1,0,1; sr_en high exactly 8 cycles.
  - frame_done at T+10; frame_word=8'hA5; frame_match=1.
- LSB-first, word 8'h0F, dir=1, rot=0:
  - sr_d = 1,1,1,1,0,0,0,0; frame_word=8'h0F; match=1.
- Rotation, word 8'hA5, dir=0, rot=1:
  - SHIFT as in the basic test, then one cycle with sr_circular=1.
  - frame_word=8'h4B; match=1; frame_done at T+11.
- Rotation, word 8'h0F, dir=1, rot=4: frame_word=8'hF0, match=1; rot_in=9 saturates to 7.
- Mismatch: bench flips sr_out bit 0 before CHECK on word 8'h3C -> frame_match=0, frame_word=8'h3D.
- Reset and handshake:
  - rstn low during SHIFT bit 3: all outputs 0 immediately, word_ready=1, no frame_done.
  - Valid held continuously: accepts exactly once per frame, at IDLE only.
